arb_wrr_scheduler: RTL and testbench

//  Weighted round-robin scheduler for one shared interconnect channel (e.g. AW/AR slave port).

---
 rtl/arb_pkg.sv | 24 ++
 rtl/arb_rr_pick.sv | 45 ++++
 rtl/arb_wrr_scheduler.sv | 147 ++++++++++++++
 tb/tb_arb_wrr_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter slice:
// FSM state encoding, index-width sizing and one-hot decoding.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int oh_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first set candidate at or after ptr,
// wrapping past N-1, via rotate / find-first / unrotate.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win_oh,
  output logic [IDX_W-1:0] win_idx
);

  logic [N-1:0] rot;
  logic [N-1:0] first;
  logic         found;

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    rot    = '0;
    first  = '0;
    win_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      rot[i] = cand[wrap(i + int'(ptr))];
    end
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (first[i]) win_oh[wrap(i + int'(ptr))] = 1'b1;
    end
  end

  assign win_idx = IDX_W'(oh_to_idx(32'(win_oh)));

endmodule

// File: rtl/arb_wrr_scheduler.sv
// Weighted round-robin scheduler for one shared channel: per-requester credit,
// rotating priority pointer, one registered grant held until accepted.
module arb_wrr_scheduler
  import arb_pkg::*;
#(
  parameter  int P_REQUESTER_NUM = 3,
  parameter  int P_WEIGHT_W      = 4,
  localparam int P_IDX_W         = clog2_min1(P_REQUESTER_NUM)
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETN,
  input  logic [P_REQUESTER_NUM-1:0]            req_i,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight_i,
  input  logic                                  grant_ready_i,
  output logic                                  grant_valid_o,
  output logic [P_REQUESTER_NUM-1:0]            grant_oh_o,
  output logic [P_IDX_W-1:0]                    grant_idx_o,
  output logic                                  round_done_o
);

  localparam int N = P_REQUESTER_NUM;
  localparam int W = P_WEIGHT_W;

  arb_state_e         state_q, state_d;
  logic [P_IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]       completed_q, completed_d;
  logic [W-1:0]       used_q [N];
  logic [W-1:0]       used_d [N];
  logic [W-1:0]       weight_q [N];
  logic [W-1:0]       weight_d [N];
  logic               grant_valid_q, grant_valid_d;
  logic [N-1:0]       grant_oh_q, grant_oh_d;
  logic [P_IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic               round_done_q, round_done_d;

  logic [N-1:0]       eligible, pick_cand, pick_oh;
  logic [P_IDX_W-1:0] pick_idx;
  logic               all_used_zero;
  logic [W:0]         used_inc;
  logic [W-1:0]       eff_weight;

  // Once every pending requester has spent its credit, restart the round from req_i.
  assign eligible  = req_i & ~completed_q;
  assign pick_cand = (eligible != '0) ? eligible : req_i;

  arb_rr_pick #(.N(N), .IDX_W(P_IDX_W)) u_pick (
    .cand    (pick_cand),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  always_comb begin
    all_used_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (used_q[i] != '0) all_used_zero = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    completed_d   = completed_q;
    used_d        = used_q;
    weight_d      = weight_q;
    grant_valid_d = grant_valid_q;
    grant_oh_d    = grant_oh_q;
    grant_idx_d   = grant_idx_q;
    round_done_d  = 1'b0;
    eff_weight    = (weight_q[grant_idx_q] == '0) ? W'(1) : weight_q[grant_idx_q];
    used_inc      = {1'b0, used_q[grant_idx_q]} + 1'b1;

    // Weights are sampled only while no credit is spent, so a round sees one set.
    if (all_used_zero) begin
      for (int i = 0; i < N; i++) weight_d[i] = weight_i[i*W +: W];
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (req_i != '0) begin
          if (eligible == '0) begin
            completed_d  = '0;
            for (int i = 0; i < N; i++) used_d[i] = '0;
            round_done_d = 1'b1;
          end
          grant_valid_d = 1'b1;
          grant_oh_d    = pick_oh;
          grant_idx_d   = pick_idx;
          state_d       = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (grant_ready_i) begin
          used_d[grant_idx_q] = used_inc[W-1:0];
          if (used_inc >= {1'b0, eff_weight}) begin
            completed_d[grant_idx_q] = 1'b1;
            ptr_d = (grant_idx_q == P_IDX_W'(N - 1)) ? '0 : grant_idx_q + 1'b1;
          end
          if (&(completed_d | ~req_i)) begin
            completed_d  = '0;
            for (int i = 0; i < N; i++) used_d[i] = '0;
            round_done_d = 1'b1;
          end
          grant_valid_d = 1'b0;
          grant_oh_d    = '0;
          grant_idx_d   = '0;
          state_d       = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= ARB_IDLE;
      ptr_q         <= '0;
      completed_q   <= '0;
      // NOTE: the credit and weight arrays are tiny flop banks, not RAM, so they take reset values.
      for (int i = 0; i < N; i++) begin
        used_q[i]   <= '0;
        weight_q[i] <= W'(1);
      end
      grant_valid_q <= 1'b0;
      grant_oh_q    <= '0;
      grant_idx_q   <= '0;
      round_done_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments; the next-state logic above uses blocking.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      completed_q   <= completed_d;
      used_q        <= used_d;
      weight_q      <= weight_d;
      grant_valid_q <= grant_valid_d;
      grant_oh_q    <= grant_oh_d;
      grant_idx_q   <= grant_idx_d;
      round_done_q  <= round_done_d;
    end
  end

  assign grant_valid_o = grant_valid_q;
  assign grant_oh_o    = grant_oh_q;
  assign grant_idx_o   = grant_idx_q;
  assign round_done_o  = round_done_q;

endmodule

// File: tb/tb_arb_wrr_scheduler.sv
// Directed bench for arb_wrr_scheduler (N=3, W=4): expected grants are queued
// when stimulus is applied and compared as each grant appears.
module tb_arb_wrr_scheduler;

  logic        ACLK;
  logic        ARESETN;
  logic [2:0]  req_i;
  logic [11:0] weight_i;
  logic        grant_ready_i;
  logic        grant_valid_o;
  logic [2:0]  grant_oh_o;
  logic [1:0]  grant_idx_o;
  logic        round_done_o;

  typedef struct {
    int idx;
    bit rd;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  arb_wrr_scheduler #(.P_REQUESTER_NUM(3), .P_WEIGHT_W(4)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .req_i         (req_i),
    .weight_i      (weight_i),
    .grant_ready_i (grant_ready_i),
    .grant_valid_o (grant_valid_o),
    .grant_oh_o    (grant_oh_o),
    .grant_idx_o   (grant_idx_o),
    .round_done_o  (round_done_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input bit rd);
    exp_t e;
    e.idx = idx;
    e.rd  = rd;
    sb.push_back(e);
  endtask

  // Called on a falling edge; returns the number of falling edges until a grant shows.
  task automatic wait_grant(output int cycles);
    cycles = 0;
    do begin
      @(negedge ACLK);
      cycles++;
    end while (grant_valid_o !== 1'b1 && cycles < 20);
  endtask

  // With ready held high: grant, then one bubble cycle carrying the round_done verdict.
  task automatic run_sb();
    exp_t e;
    int   cyc;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_grant(cyc);
      check("grant_gap", 32'(cyc), 32'd1);
      check("grant_idx", 32'(grant_idx_o), 32'(e.idx));
      check("grant_oh", 32'(grant_oh_o), 32'(1 << e.idx));
      @(negedge ACLK);
      check("bubble_valid", 32'(grant_valid_o), 32'd0);
      check("round_done", 32'(round_done_o), 32'(e.rd));
    end
  endtask

  task automatic do_reset(input logic [11:0] w);
    ARESETN       = 1'b0;
    req_i         = '0;
    grant_ready_i = 1'b0;
    weight_i      = w;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  initial begin
    int cyc;
    ARESETN       = 1'b1;
    req_i         = '0;
    grant_ready_i = 1'b0;
    weight_i      = {4'd1, 4'd1, 4'd1};
    #1 ARESETN = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    check("rst_valid", 32'(grant_valid_o), 32'd0);
    check("rst_oh", 32'(grant_oh_o), 32'd0);
    check("rst_idx", 32'(grant_idx_o), 32'd0);
    check("rst_round_done", 32'(round_done_o), 32'd0);
    ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("idle_valid", 32'(grant_valid_o), 32'd0);
    end

    // 1: reset asserted while a grant is held drops every output at once.
    req_i = 3'b001;
    wait_grant(cyc);
    check("t1_latency", 32'(cyc), 32'd1);
    check("t1_valid", 32'(grant_valid_o), 32'd1);
    ARESETN = 1'b0;
    #1;
    check("t1_async_valid", 32'(grant_valid_o), 32'd0);
    check("t1_async_oh", 32'(grant_oh_o), 32'd0);
    check("t1_async_idx", 32'(grant_idx_o), 32'd0);
    check("t1_async_rd", 32'(round_done_o), 32'd0);
    @(negedge ACLK);
    req_i   = '0;
    ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("t1_idle_valid", 32'(grant_valid_o), 32'd0);
      check("t1_idle_oh", 32'(grant_oh_o), 32'd0);
    end

    // 2: equal weights, all requesting.
    do_reset({4'd1, 4'd1, 4'd1});
    grant_ready_i = 1'b1;
    req_i         = 3'b111;
    push(0, 0); push(1, 0); push(2, 1);
    push(0, 0); push(1, 0); push(2, 1);
    run_sb();

    // 3: weights idx0=3, idx1=1, idx2=2.
    do_reset({4'd1, 4'd1, 4'd1});
    weight_i      = {4'd2, 4'd1, 4'd3};
    grant_ready_i = 1'b1;
    req_i         = 3'b111;
    for (int r = 0; r < 2; r++) begin
      push(0, 0); push(0, 0); push(0, 0);
      push(1, 0); push(2, 0); push(2, 1);
    end
    run_sb();

    // 4: lone requester 0 wins through the wrapped pointer every round.
    do_reset({4'd1, 4'd1, 4'd1});
    grant_ready_i = 1'b1;
    req_i         = 3'b001;
    for (int r = 0; r < 4; r++) push(0, 1);
    run_sb();

    // 5: backpressure on idx1 (weight 2); request drops and returns while held.
    do_reset({4'd1, 4'd2, 4'd1});
    req_i = 3'b010;
    wait_grant(cyc);
    check("t5_latency", 32'(cyc), 32'd1);
    check("t5_idx", 32'(grant_idx_o), 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge ACLK);
      check("t5_hold_valid", 32'(grant_valid_o), 32'd1);
      check("t5_hold_oh", 32'(grant_oh_o), 32'b010);
      if (c == 2) req_i = 3'b000;
      if (c == 4) req_i = 3'b010;
    end
    grant_ready_i = 1'b1;
    @(negedge ACLK);
    check("t5_bubble_valid", 32'(grant_valid_o), 32'd0);
    check("t5_credit_left", 32'(round_done_o), 32'd0);
    push(1, 1);
    run_sb();

    // 6: weight of idx0 drops 3->1 after its first grant; takes effect next round.
    do_reset({4'd1, 4'd1, 4'd3});
    grant_ready_i = 1'b1;
    req_i         = 3'b111;
    push(0, 0);
    run_sb();
    weight_i = {4'd1, 4'd1, 4'd1};
    push(0, 0); push(0, 0); push(1, 0); push(2, 1);
    push(0, 0); push(1, 0); push(2, 1);
    run_sb();

    do_reset({4'd1, 4'd1, 4'd1});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
